// File: rtl/conv_pkg.sv
// Shared definitions for the conv weight path: state encoding of the weight
// fetcher and the default widths, which must agree with the weight memory.
package conv_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 10;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/weight_fetch_fifo.sv
// Small synchronous FIFO that buffers weight words between the memory read
// port and the output stream; head word is presented combinationally.
module weight_fetch_fifo
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_W-1:0]      count
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_fire;
    logic                  rd_fire;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign wr_fire = wr_en & ~full;
    assign rd_fire = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_fire) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/weight_fetch.sv
// Weight fetcher: reads num_words consecutive weights from the conv weight
// memory and streams them out, using FIFO credits to survive backpressure.
module weight_fetch
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_read_req,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  w_valid,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_last,
    input  logic                  w_ready,
    output fetch_state_e          state_dbg
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e          state_q;
    fetch_state_e          state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   num_q;
    logic [ADDR_WIDTH:0]   issue_cnt;
    logic [ADDR_WIDTH:0]   accept_cnt;
    logic                  inflight_q;
    logic                  accept_start;
    logic                  pop;
    logic                  issue_room;
    logic                  more_to_issue;
    logic [CNT_W:0]        credit_used;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [DATA_WIDTH-1:0] fifo_head;

    // A word is buffered or in flight for every credit used; a request is only
    // issued when a FIFO slot is guaranteed for its data next cycle.
    assign credit_used   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign issue_room    = (credit_used < (CNT_W+1)'(FIFO_DEPTH)) && !fifo_full;
    assign more_to_issue = (issue_cnt < num_q);

    // Stream handshake: a word transfers on a rising edge where w_valid and
    // w_ready are both high; w_valid/w_data do not depend on w_ready and hold
    // steady until that transfer.
    assign pop = w_valid & w_ready;

    always_comb begin
        state_d      = state_q;
        mem_read_req = 1'b0;
        accept_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_d      = (num_words == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                mem_read_req = issue_room && more_to_issue;
                if (!more_to_issue) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && w_last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            num_q      <= '0;
            issue_cnt  <= '0;
            accept_cnt <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= mem_read_req;
            if (accept_start) begin
                base_q     <= base_addr;
                num_q      <= num_words;
                issue_cnt  <= '0;
                accept_cnt <= '0;
            end else begin
                if (mem_read_req) issue_cnt  <= issue_cnt + (ADDR_WIDTH+1)'(1);
                if (pop)          accept_cnt <= accept_cnt + (ADDR_WIDTH+1)'(1);
            end
        end
    end

    // Address arithmetic is ADDR_WIDTH wide, so the top of memory wraps to 0.
    assign mem_read_addr = mem_read_req ? (base_q + issue_cnt[ADDR_WIDTH-1:0]) : '0;

    assign busy      = (state_q == FETCH) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;

    assign w_valid = !fifo_empty;
    assign w_data  = fifo_empty ? '0 : fifo_head;
    assign w_last  = w_valid && ((accept_cnt + (ADDR_WIDTH+1)'(1)) == num_q);

    weight_fetch_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (inflight_q),
        .wr_data (mem_read_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_weight_fetch.sv
// Self-checking bench for weight_fetch: memory model, expected-word and
// expected-address queues, and directed plus random fetch jobs.
module tb_weight_fetch;
    import conv_pkg::*;

    logic         clk;
    logic         reset;
    logic         start;
    logic [9:0]   base_addr;
    logic [10:0]  num_words;
    logic         busy;
    logic         done;
    logic         mem_read_req;
    logic [9:0]   mem_read_addr;
    logic [7:0]   mem_read_data;
    logic         w_valid;
    logic [7:0]   w_data;
    logic         w_last;
    logic         w_ready;
    fetch_state_e state_dbg;

    weight_fetch #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (10),
        .FIFO_DEPTH (4)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .num_words     (num_words),
        .busy          (busy),
        .done          (done),
        .mem_read_req  (mem_read_req),
        .mem_read_addr (mem_read_addr),
        .mem_read_data (mem_read_data),
        .w_valid       (w_valid),
        .w_data        (w_data),
        .w_last        (w_last),
        .w_ready       (w_ready),
        .state_dbg     (state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // weight memory model: one-cycle read latency, garbage when idle
    logic [7:0] mem_model [1024];
    always @(posedge clk) begin
        if (mem_read_req) mem_read_data <= mem_model[mem_read_addr];
        else              mem_read_data <= 8'($urandom);
    end

    // scoreboard
    logic [8:0] exp_q[$];
    logic [9:0] addr_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    int job_seq = 0;
    int start_cyc = 0;
    int mon_seq = 0;
    int done_total = 0, busy_total = 0, req_total = 0, valid_total = 0;
    int last_total = 0, hs_total = 0;
    int done_cyc = -1, last_hs_cyc = -1, first_valid_cyc = -1;
    int first_req_cyc = -1, last_req_cyc = -1;
    logic busy_at_done = 1'b0;
    logic stalled_prev = 1'b0;
    logic [7:0] held_data = '0;

    // monitor: samples on the falling edge, away from the active edge
    always @(negedge clk) begin
        logic [8:0] ent;
        if (!reset) begin
            stalled_prev = 1'b0;
        end else begin
            if (mon_seq != job_seq) begin
                mon_seq = job_seq;
                first_valid_cyc = -1;
                first_req_cyc = -1;
            end
            if (busy) begin
                busy_total++;
                chk("credit", 32'((32'(u_dut.fifo_count) + 32'(u_dut.inflight_q)) <= 32'd4), 32'd1);
            end
            if (u_dut.u_fifo.wr_en) chk("fifo_ovf", 32'(u_dut.u_fifo.full), 32'd0);
            if (done) begin
                done_total++;
                done_cyc = cyc;
                busy_at_done = busy;
            end
            if (mem_read_req) begin
                req_total++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
                last_req_cyc = cyc;
                if (addr_q.size() == 0) chk("extra_req", 32'(mem_read_addr), 32'h3ff_dead);
                else chk("req_addr", 32'(mem_read_addr), 32'(addr_q.pop_front()));
            end
            if (w_valid) begin
                valid_total++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (stalled_prev) chk("stall_hold", 32'(w_data), 32'(held_data));
            end
            if (w_valid && w_ready) begin
                hs_total++;
                if (w_last) last_total++;
                if (exp_q.size() == 0) begin
                    chk("extra_word", 32'(w_data), 32'hdead_beef);
                end else begin
                    ent = exp_q.pop_front();
                    chk("w_data", 32'(w_data), 32'(ent[7:0]));
                    chk("w_last", 32'(w_last), 32'(ent[8]));
                    if (ent[8]) last_hs_cyc = cyc;
                end
            end
            stalled_prev = w_valid && !w_ready;
            held_data = w_data;
        end
    end

    // driver: pushes expectations, pulses start, drives w_ready until done
    task automatic push_job(input int base, input int num);
        int a;
        for (int i = 0; i < num; i++) begin
            a = (base + i) % 1024;
            addr_q.push_back(10'(a));
            exp_q.push_back({(i == num - 1), mem_model[a]});
        end
    endtask

    task automatic drive_start(input int base, input int num);
        @(posedge clk); #2;
        start = 1'b1;
        base_addr = 10'(base);
        num_words = 11'(num);
        w_ready = 1'b1;
        start_cyc = cyc;
        job_seq++;
    endtask

    task automatic run_job(input int base, input int num, input bit bp, input bit inject);
        int spin;
        int d0;
        push_job(base, num);
        d0 = done_total;
        drive_start(base, num);
        spin = 0;
        while (done_total == d0 && spin < 400) begin
            @(posedge clk); #2;
            spin++;
            start = 1'b0;
            if (inject && spin == 5) begin
                start = 1'b1;
                base_addr = 10'd100;
                num_words = 11'd3;
            end
            w_ready = bp ? ((spin % 4 == 0) || (spin % 4 == 3)) : 1'b1;
        end
        start = 1'b0;
        chk("done_timeout", 32'(spin < 400), 32'd1);
        repeat (4) @(posedge clk);
        #2;
        w_ready = 1'b1;
        chk("done_count", 32'(done_total - d0), 32'd1);
        chk("exp_left", 32'(exp_q.size()), 32'd0);
        chk("addr_left", 32'(addr_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(tag, 32'({busy, done, mem_read_req, w_valid, w_last, mem_read_addr, w_data}), 32'd0);
        chk({tag, "_fifo"}, 32'(u_dut.fifo_count), 32'd0);
        chk({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    endtask

    initial begin
        int r0, v0, b0, l0, h0, spin;
        reset = 1'b0;
        start = 1'b0;
        base_addr = '0;
        num_words = '0;
        w_ready = 1'b1;
        for (int i = 0; i < 1024; i++) mem_model[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // basic job with latency checks
        l0 = last_total;
        r0 = req_total;
        run_job(0, 9, 1'b0, 1'b0);
        chk("first_req_lat", 32'(first_req_cyc - start_cyc), 32'd1);
        chk("last_req_lat", 32'(last_req_cyc - start_cyc), 32'd9);
        chk("req_count", 32'(req_total - r0), 32'd9);
        chk("first_valid_lat", 32'(first_valid_cyc - start_cyc), 32'd3);
        chk("done_lat", 32'(done_cyc - last_hs_cyc), 32'd1);
        chk("busy_at_done", 32'(busy_at_done), 32'd0);
        chk("last_count", 32'(last_total - l0), 32'd1);

        // backpressure 1,0,0,1
        run_job(37, 16, 1'b1, 1'b0);

        // address wrap
        run_job(1022, 4, 1'b0, 1'b0);

        // zero length
        r0 = req_total;
        v0 = valid_total;
        b0 = busy_total;
        run_job(5, 0, 1'b0, 1'b0);
        chk("zero_req", 32'(req_total - r0), 32'd0);
        chk("zero_valid", 32'(valid_total - v0), 32'd0);
        chk("zero_busy", 32'(busy_total - b0), 32'd0);
        chk("zero_done_lat", 32'(done_cyc - start_cyc), 32'd1);

        // start while busy is ignored
        run_job(200, 12, 1'b1, 1'b1);

        // reset after three words delivered
        push_job(300, 16);
        h0 = hs_total;
        drive_start(300, 16);
        spin = 0;
        while ((hs_total - h0) < 3 && spin < 100) begin
            @(posedge clk); #2;
            start = 1'b0;
            spin++;
        end
        chk("rst_wait", 32'(spin < 100), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_outputs("midjob_reset");
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        run_job(512, 7, 1'b0, 1'b0);

        // random jobs
        for (int j = 0; j < 4; j++)
            run_job(int'($urandom_range(0, 1023)), int'($urandom_range(1, 20)),
                    1'($urandom_range(0, 1)), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/weight_fetch.md
Name: weight_fetch

Overview:
- Read initiator for the conv weight memory; drives its single read port (req, addr; data returns 1 cycle later, no stall).
- On `start`, fetches `num_words` consecutive weights beginning at `base_addr`.
- Streams the fetched weights to the conv datapath over a valid/ready interface.
- An internal credit-limited FIFO absorbs memory latency so downstream backpressure never drops data.

Parameters:
- DATA_WIDTH, 8, weight word width; must match the memory data width.
- ADDR_WIDTH, 10, memory address width.
- FIFO_DEPTH, 4, output buffer entries (power of 2, >=2).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a fetch job; honoured only in IDLE.
- base_addr  input  ADDR_WIDTH  first word address, sampled with start.
- num_words  input  ADDR_WIDTH+1  number of words to fetch, sampled with start.
- busy  output  1  high from the cycle after an accepted start until the cycle done pulses.
- done  output  1  one-cycle pulse when the job completes.
- mem_read_req  output  1  read request to the weight memory.
- mem_read_addr  output  ADDR_WIDTH  read address, valid when mem_read_req=1.
- mem_read_data  input  DATA_WIDTH  memory data, valid exactly 1 cycle after a req.
- w_valid  output  1  output stream valid.
- w_data  output  DATA_WIDTH  weight word.
- w_last  output  1  marks the final word of the job.
- w_ready  input  1  downstream accept.

Behaviour:
- Reset (reset=0, asynchronous):
  - busy, done, mem_read_req, w_valid, w_last = 0; mem_read_addr, w_data = 0.
  - FIFO emptied; state = IDLE; in-flight flag cleared.
  - Applies immediately mid-job; any returning memory data is discarded.
- States: IDLE, FETCH, DRAIN, DONE.
  - IDLE: start=1 and num_words!=0 -> FETCH. Latch base_addr and num_words; issue count = 0; accept count = 0.
  - IDLE: start=1 and num_words=0 -> DONE. No memory requests, no stream output.
  - FETCH -> DRAIN once issue count reaches num_words.
  - DRAIN -> DONE on handshake (w_valid & w_ready) of the word with w_last=1.
  - DONE: done=1 for one cycle -> IDLE.
  - start in any state other than IDLE is ignored.
- Request issue (FETCH only), combinational from registered state:
  - mem_read_req = 1 when fifo_count + inflight < FIFO_DEPTH and issue count < num_words.
  - inflight = 1-bit register, set to mem_read_req of the previous cycle.
  - mem_read_addr = base_addr + issue count, modulo 2^ADDR_WIDTH (1023 wraps to 0).
- Data capture: in the cycle after a req, mem_read_data is written into the FIFO. The credit rule guarantees the FIFO is never full at write time; an overflow is a design error, so the bench asserts against it.
- Output: w_valid = FIFO not empty; w_data = FIFO head.
  - w_last = 1 when the head word is word index num_words-1 (tracked via accept count).
  - Pop on w_valid & w_ready.
  - w_data holds stable while w_valid=1 and w_ready=0.
- Simultaneous FIFO write and pop in the same cycle: count unchanged; both take effect.
- Latency with w_ready=1:
  - start high in cycle 0 -> req for base_addr in cycle 1 -> data captured at end of cycle 2 -> w_valid in cycle 3.
  - Sustained throughput is 1 word/cycle.
  - done pulses in the cycle after the last handshake; busy is low from that same cycle.
- busy = 1 in FETCH and DRAIN, 0 in IDLE and DONE.

Decomposition:
- Shared package (conv_pkg):
  - state encoding enum {IDLE, FETCH, DRAIN, DONE}.
  - Default DATA_WIDTH / ADDR_WIDTH constants, shared with the weight memory.
- Sub-module: weight_fetch_fifo.
  - Synchronous FIFO, parameters DATA_WIDTH and FIFO_DEPTH.
  - Ports: wr_en, wr_data, rd_en, rd_data, empty, full, count.
  - Asynchronous active-low reset.

Test Plan:
- Basic: base_addr=0, num_words=9, w_ready=1 -> addrs 0..8 issued on consecutive cycles; 9 words out matching memory[0..8]; w_last only on the 9th; first w_valid 3 cycles after start; done 1 cycle after the last handshake.
- Backpressure: num_words=16, w_ready toggled 1,0,0,1 repeating -> no word lost or duplicated; output order = memory[base..base+15]; fifo_count + inflight never exceeds 4; w_data stable while stalled.
- Wrap-around: base_addr=1022, num_words=4 -> addrs issued 1022, 1023, 0, 1.
- Zero length: num_words=0 -> no mem_read_req, no w_valid; done pulses 1 cycle after start; busy never asserted.
- Start while busy: second start (base_addr=100) mid-job -> ignored; the job completes with the original parameters and only one done pulse.
- Reset mid-job: assert reset after 3 words delivered -> all outputs 0 immediately; FIFO empty; a new job after release runs cleanly with correct data.
